// File: rtl/pipe_instr_track.sv
// pipe_instr_track
//   Front-end pipeline sequencer. Owns the fetch PC and the IF/ID, ID/EX,
//   EX/MEM and MEM/WB instruction registers. Each cycle it does one of three
//   things, selected by the hazard detector and the ID-stage branch result:
//     advance  - everything moves down one stage, PC steps by 4
//     stall    - PC and IF/ID hold, a bubble enters ID/EX
//     redirect - PC jumps to the branch target, the wrong-path fetch is squashed
//   Stall and flush cycles are counted in saturating counters for debug.
//
// Ports
//   clk           in   single clock, rising-edge
//   rst           in   asynchronous active-high reset
//   imem_instr    in   fetched word for address pc
//   id_stall      in   hazard hold request (wins over br_taken)
//   br_taken      in   branch in IF/ID resolved taken
//   br_target     in   branch target address (low two bits dropped)
//   pc            out  current fetch address
//   if_id_instr   out  instruction in decode
//   if_id_pc      out  PC of the instruction in decode
//   id_ex_instr   out  instruction in execute
//   ex_mem_instr  out  instruction in memory
//   mem_wb_instr  out  instruction in writeback
//   stall_cnt     out  saturating count of stall cycles
//   flush_cnt     out  saturating count of taken-branch flushes
module pipe_instr_track #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      imem_instr,
    input  logic             id_stall,
    input  logic             br_taken,
    input  logic [31:0]      br_target,
    output logic [31:0]      pc,
    output logic [31:0]      if_id_instr,
    output logic [31:0]      if_id_pc,
    output logic [31:0]      id_ex_instr,
    output logic [31:0]      ex_mem_instr,
    output logic [31:0]      mem_wb_instr,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        MODE_ADVANCE,
        MODE_STALL,
        MODE_REDIRECT
    } mode_t;

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    mode_t mode;

    // A branch whose operand is still in flight is not really resolved, so
    // the stall request overrides br_taken.
    always_comb begin
        mode = MODE_ADVANCE;
        if (id_stall) begin
            mode = MODE_STALL;
        end else if (br_taken) begin
            mode = MODE_REDIRECT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc           <= RESET_PC;
            if_id_instr  <= NOP_INSTR;
            if_id_pc     <= 32'h0000_0000;
            id_ex_instr  <= NOP_INSTR;
            ex_mem_instr <= NOP_INSTR;
            mem_wb_instr <= NOP_INSTR;
            stall_cnt    <= '0;
            flush_cnt    <= '0;
        end else begin
            // The back half of the pipe never stalls.
            ex_mem_instr <= id_ex_instr;
            mem_wb_instr <= ex_mem_instr;
            case (mode)
                MODE_STALL: begin
                    id_ex_instr <= NOP_INSTR;
                    if (stall_cnt != CNT_MAX) begin
                        stall_cnt <= stall_cnt + CNT_ONE;
                    end
                end
                MODE_REDIRECT: begin
                    pc          <= {br_target[31:2], 2'b00};
                    if_id_instr <= NOP_INSTR;
                    if_id_pc    <= 32'h0000_0000;
                    id_ex_instr <= if_id_instr;
                    if (flush_cnt != CNT_MAX) begin
                        flush_cnt <= flush_cnt + CNT_ONE;
                    end
                end
                default: begin
                    pc          <= pc + 32'd4;
                    if_id_instr <= imem_instr;
                    if_id_pc    <= pc;
                    id_ex_instr <= if_id_instr;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_instr_track.sv
// tb_pipe_instr_track
//   Directed bench for pipe_instr_track. The driver issues one cycle of
//   inputs and pushes the hand-computed register snapshot expected after the
//   following rising edge; a monitor pops and compares on each falling edge.
//   Instruction memory returns pc ^ A500_0000 so every fetched word is distinct.
module tb_pipe_instr_track;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct {
        string       name;
        logic [31:0] pc;
        logic [31:0] ifi;
        logic [31:0] ifp;
        logic [31:0] idex;
        logic [31:0] exm;
        logic [31:0] mwb;
        logic [15:0] sc;
        logic [15:0] fc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] imem_instr;
    logic        id_stall = 1'b0;
    logic        br_taken = 1'b0;
    logic [31:0] br_target = 32'h0;
    logic [31:0] pc;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc;
    logic [31:0] id_ex_instr;
    logic [31:0] ex_mem_instr;
    logic [31:0] mem_wb_instr;
    logic [15:0] stall_cnt;
    logic [15:0] flush_cnt;

    int tests_run    = 0;
    int tests_failed = 0;
    exp_t sb_q[$];

    pipe_instr_track #(
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(32'h0000_0013),
        .CNT_W    (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_instr  (imem_instr),
        .id_stall    (id_stall),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .pc          (pc),
        .if_id_instr (if_id_instr),
        .if_id_pc    (if_id_pc),
        .id_ex_instr (id_ex_instr),
        .ex_mem_instr(ex_mem_instr),
        .mem_wb_instr(mem_wb_instr),
        .stall_cnt   (stall_cnt),
        .flush_cnt   (flush_cnt)
    );

    always #5 clk = ~clk;

    assign imem_instr = pc ^ 32'hA500_0000;

    function automatic logic [31:0] w(input logic [31:0] addr);
        return addr ^ 32'hA500_0000;
    endfunction

    function automatic exp_t mk(input string name, input logic [31:0] p,
                                input logic [31:0] ifi, input logic [31:0] ifp,
                                input logic [31:0] idex, input logic [31:0] exm,
                                input logic [31:0] mwb, input logic [15:0] sc,
                                input logic [15:0] fc);
        exp_t e;
        e.name = name; e.pc = p; e.ifi = ifi; e.ifp = ifp;
        e.idex = idex; e.exm = exm; e.mwb = mwb; e.sc = sc; e.fc = fc;
        return e;
    endfunction

    task automatic check_state(input exp_t e);
        tests_run++;
        if (pc !== e.pc || if_id_instr !== e.ifi || if_id_pc !== e.ifp ||
            id_ex_instr !== e.idex || ex_mem_instr !== e.exm ||
            mem_wb_instr !== e.mwb || stall_cnt !== e.sc || flush_cnt !== e.fc) begin
            tests_failed++;
            $display("FAIL %s: got pc=%h if=%h ifpc=%h idex=%h exm=%h mwb=%h sc=%h fc=%h | want pc=%h if=%h ifpc=%h idex=%h exm=%h mwb=%h sc=%h fc=%h",
                     e.name, pc, if_id_instr, if_id_pc, id_ex_instr, ex_mem_instr,
                     mem_wb_instr, stall_cnt, flush_cnt, e.pc, e.ifi, e.ifp,
                     e.idex, e.exm, e.mwb, e.sc, e.fc);
        end
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            check_state(sb_q.pop_front());
        end
    end

    task automatic drive(input logic s, input logic t, input logic [31:0] tgt);
        id_stall  = s;
        br_taken  = t;
        br_target = tgt;
    endtask

    task automatic expect_after_edge(input exp_t e);
        @(posedge clk);
        #1;
        sb_q.push_back(e);
    endtask

    task automatic step(input logic s, input logic t, input logic [31:0] tgt,
                        input exp_t e);
        @(negedge clk);
        drive(s, t, tgt);
        expect_after_edge(e);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, want completion");
        tests_failed++;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e_rst;
        e_rst = mk("reset", 32'h0, NOP, 32'h0, NOP, NOP, NOP, 16'h0, 16'h0);

        // Initial reset, held across a rising edge.
        #1;
        sb_q.push_back(e_rst);
        @(negedge clk);
        #3;
        rst = 1'b0;

        // T2 straight-line: first edge after reset fetches RESET_PC.
        drive(1'b0, 1'b0, 32'h0);
        expect_after_edge(mk("adv1", 32'h4, w(32'h0), 32'h0, NOP, NOP, NOP, 16'h0, 16'h0));
        step(1'b0, 1'b0, 32'h0, mk("adv2", 32'h8, w(32'h4), 32'h4, w(32'h0), NOP, NOP, 16'h0, 16'h0));
        step(1'b0, 1'b0, 32'h0, mk("adv3", 32'hC, w(32'h8), 32'h8, w(32'h4), w(32'h0), NOP, 16'h0, 16'h0));
        step(1'b0, 1'b0, 32'h0, mk("adv4", 32'h10, w(32'hC), 32'hC, w(32'h8), w(32'h4), w(32'h0), 16'h0, 16'h0));

        // T3 load-use: w(8) acts as the load in ID/EX, w(C) as the dependent branch.
        step(1'b1, 1'b0, 32'h0, mk("stall1", 32'h10, w(32'hC), 32'hC, NOP, w(32'h8), w(32'h4), 16'h1, 16'h0));
        step(1'b1, 1'b0, 32'h0, mk("stall2", 32'h10, w(32'hC), 32'hC, NOP, NOP, w(32'h8), 16'h2, 16'h0));

        // T5 priority: stall and taken together behave as a stall.
        step(1'b1, 1'b1, 32'h0000_0203, mk("prio_stall", 32'h10, w(32'hC), 32'hC, NOP, NOP, NOP, 16'h3, 16'h0));

        // T4/T5 redirect once the stall drops; target low bits are dropped.
        step(1'b0, 1'b1, 32'h0000_0103, mk("redirect", 32'h100, NOP, 32'h0, w(32'hC), NOP, NOP, 16'h3, 16'h1));
        step(1'b0, 1'b0, 32'h0, mk("adv_tgt", 32'h104, w(32'h100), 32'h100, NOP, w(32'hC), NOP, 16'h3, 16'h1));

        // T6 PC wrap: redirect to the top word, then advance.
        step(1'b0, 1'b1, 32'hFFFF_FFFE, mk("redirect_top", 32'hFFFF_FFFC, NOP, 32'h0, w(32'h100), NOP, w(32'hC), 16'h3, 16'h2));
        step(1'b0, 1'b0, 32'h0, mk("pc_wrap", 32'h0, w(32'hFFFF_FFFC), 32'hFFFF_FFFC, NOP, w(32'h100), NOP, 16'h3, 16'h2));
        step(1'b0, 1'b0, 32'h0, mk("adv_after_wrap", 32'h4, w(32'h0), 32'h0, w(32'hFFFF_FFFC), NOP, w(32'h100), 16'h3, 16'h2));

        // T1 reset mid-run: effective immediately, no clock edge needed.
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_state(mk("reset_async", 32'h0, NOP, 32'h0, NOP, NOP, NOP, 16'h0, 16'h0));
        sb_q.push_back(mk("reset_hold", 32'h0, NOP, 32'h0, NOP, NOP, NOP, 16'h0, 16'h0));
        @(negedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        expect_after_edge(mk("refetch", 32'h4, w(32'h0), 32'h0, NOP, NOP, NOP, 16'h0, 16'h0));

        // T6 counter saturation: run stall_cnt up to all-ones and beyond.
        for (int i = 1; i <= 65537; i++) begin
            @(negedge clk);
            drive(1'b1, 1'b0, 32'h0);
            if (i >= 65534) begin
                expect_after_edge(mk("stall_sat", 32'h4, w(32'h0), 32'h0, NOP, NOP, NOP,
                                     (i >= 65535) ? 16'hFFFF : 16'(i), 16'h0));
            end
        end

        @(negedge clk);
        drive(1'b0, 1'b0, 32'h0);
        for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (sb_q.size() > 0) begin
            tests_failed++;
            $display("FAIL drain: got %0d pending, want 0", sb_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
